// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the block-granular main memory.
package mem_pkg;
  localparam int ADDR_BITS   = 10;
  localparam int BLOCK_BITS  = 128;
  localparam int BYTE_BITS   = 8;
  localparam int NUM_BLOCKS  = 64;
  localparam int OFFSET_BITS = 4;
  localparam int INDEX_BITS  = ADDR_BITS - OFFSET_BITS;
  localparam int CNT_BITS    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/main_memory_seq_if.sv
// Cache-side request/ready/valid bus of the main memory.
interface main_memory_seq_if #(
  parameter int ADDR_BITS  = 10,
  parameter int BLOCK_BITS = 128
);
  logic                  in_req;
  logic                  in_row;
  logic [ADDR_BITS-1:0]  in_addr;
  logic [BLOCK_BITS-1:0] in_write_data;
  logic                  out_ready;
  logic                  out_valid;
  logic [BLOCK_BITS-1:0] out_read_data;

  modport master (
    output in_req, in_row, in_addr, in_write_data,
    input  out_ready, out_valid, out_read_data
  );

  modport slave (
    input  in_req, in_row, in_addr, in_write_data,
    output out_ready, out_valid, out_read_data
  );
endinterface

// File: rtl/mem_block_array.sv
// 64 x 128-bit block store with async clear, one write port and one registered block read port.
// MAIN_MEM_DEBUG_PORT_EN adds a combinational byte read port.
module mem_block_array
  import mem_pkg::*;
#(
  parameter int BLK_BITS = 128,
  parameter int N_BLOCKS = 64,
  parameter int IDX_BITS = 6
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                we,
  input  logic [IDX_BITS-1:0] waddr,
  input  logic [BLK_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IDX_BITS-1:0] raddr,
  output logic [BLK_BITS-1:0] rdata
`ifdef MAIN_MEM_DEBUG_PORT_EN
  ,
  input  logic [IDX_BITS+OFFSET_BITS-1:0] dbg_addr,
  output logic [BYTE_BITS-1:0]            dbg_byte
`endif
);
  logic [BLK_BITS-1:0] mem_q [N_BLOCKS];
  logic [BLK_BITS-1:0] rdata_q;
  logic [BLK_BITS-1:0] rdata_d;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < N_BLOCKS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

`ifdef MAIN_MEM_DEBUG_PORT_EN
  logic [BLK_BITS-1:0] dbg_block;
  logic [6:0]          dbg_bit;

  always_comb begin
    dbg_block = mem_q[dbg_addr[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS]];
    dbg_bit   = {dbg_addr[OFFSET_BITS-1:0], 3'b000};
    dbg_byte  = dbg_block[dbg_bit +: BYTE_BITS];
  end
`endif
endmodule

// File: rtl/main_memory_seq.sv
// Fixed-latency, single-outstanding block memory servicing cache refills and write-backs.
// Optional debug port (byte peek + committed-write counter) under MAIN_MEM_DEBUG_PORT_EN.
module main_memory_seq #(
  parameter int LATENCY    = 4,
  parameter int ADDR_BITS  = 10,
  parameter int BLOCK_BITS = 128
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  main_memory_seq_if.slave  bus
`ifdef MAIN_MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_BITS-1:0] in_dbg_addr,
  output logic [7:0]           out_dbg_byte,
  output logic [15:0]          out_dbg_writes
`endif
);
  import mem_pkg::*;

  localparam int IDX_BITS = ADDR_BITS - OFFSET_BITS;

  mem_state_t            state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  row_q, row_d;
  logic [IDX_BITS-1:0]   blk_q, blk_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  enter_done;
  logic                  arr_we;
  logic                  arr_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    blk_d   = blk_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_req) begin
          row_d   = bus.in_row;
          blk_d   = bus.in_addr[ADDR_BITS-1:OFFSET_BITS];
          wdata_d = bus.in_write_data;
          if (LATENCY == 1) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_BITS'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // On the DONE entry edge the *_d operands hold the live request (LATENCY=1) or the captured one.
    enter_done = (state_d == DONE) && (state_q != DONE);
    arr_we     = enter_done && row_d;
    arr_re     = enter_done && !row_d;
    ready_d    = (state_d == IDLE);
    valid_d    = (state_d == DONE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= 1'b0;
      blk_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  mem_block_array #(
    .BLK_BITS (BLOCK_BITS),
    .N_BLOCKS (NUM_BLOCKS),
    .IDX_BITS (IDX_BITS)
  ) u_array (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .we       (arr_we),
    .waddr    (blk_d),
    .wdata    (wdata_d),
    .re       (arr_re),
    .raddr    (blk_d),
    .rdata    (bus.out_read_data)
`ifdef MAIN_MEM_DEBUG_PORT_EN
    ,
    .dbg_addr (in_dbg_addr),
    .dbg_byte (out_dbg_byte)
`endif
  );

  assign bus.out_ready = ready_q;
  assign bus.out_valid = valid_q;

`ifdef MAIN_MEM_DEBUG_PORT_EN
  logic [15:0] dbg_writes_q, dbg_writes_d;

  always_comb begin
    dbg_writes_d = dbg_writes_q;
    if (arr_we && (dbg_writes_q != 16'hFFFF)) begin
      dbg_writes_d = dbg_writes_q + 16'd1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      dbg_writes_q <= '0;
    end else begin
      dbg_writes_q <= dbg_writes_d;
    end
  end

  assign out_dbg_writes = dbg_writes_q;
`endif
endmodule

// File: tb/tb_main_memory_seq.sv
// Scoreboard bench for main_memory_seq: a driver pushes expectations from an array model,
// a negedge monitor pops and compares on out_valid; a second LATENCY=1 instance checks the fast path.
module tb_main_memory_seq;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_memory_seq_if bus0 ();
  main_memory_seq_if bus1 ();

`ifdef MAIN_MEM_DEBUG_PORT_EN
  logic [9:0]  dbg_addr  = '0;
  logic [7:0]  dbg_byte;
  logic [15:0] dbg_writes;
  logic [9:0]  dbg1_addr = '0;
  logic [7:0]  dbg1_byte;
  logic [15:0] dbg1_writes;
`endif

  main_memory_seq #(.LATENCY(LAT)) dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus0)
`ifdef MAIN_MEM_DEBUG_PORT_EN
    ,
    .in_dbg_addr    (dbg_addr),
    .out_dbg_byte   (dbg_byte),
    .out_dbg_writes (dbg_writes)
`endif
  );

  main_memory_seq #(.LATENCY(1)) dut1 (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus1)
`ifdef MAIN_MEM_DEBUG_PORT_EN
    ,
    .in_dbg_addr    (dbg1_addr),
    .out_dbg_byte   (dbg1_byte),
    .out_dbg_writes (dbg1_writes)
`endif
  );

  typedef struct {
    bit           is_read;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] ref_mem [64];
  logic [127:0] last_rd = '0;
  int           cyc = 0;
  int           acc = 0;
  bit           acc_valid = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: ready window and completion checks for the LATENCY=4 instance.
  always @(negedge clk) begin
    bit   rexp;
    exp_t e;
    if (!rst_n) begin
      chk("rst_ready", 128'(bus0.out_ready), 128'(1));
      chk("rst_valid", 128'(bus0.out_valid), 128'(0));
      chk("rst_rdata", bus0.out_read_data, 128'(0));
    end else begin
      rexp = !(acc_valid && (cyc >= acc + 1) && (cyc <= acc + LAT + 1));
      chk("ready", 128'(bus0.out_ready), 128'(rexp));
      if ((exp_q.size() > 0) && (cyc >= exp_q[0].due)) begin
        e = exp_q.pop_front();
        chk("valid_on_time", 128'(bus0.out_valid), 128'(1));
        if (e.is_read) begin
          chk("read_data", bus0.out_read_data, e.data);
          last_rd = e.data;
        end else begin
          chk("rdata_hold_on_write", bus0.out_read_data, last_rd);
        end
        $display("txn %s done at cycle %0d data=%h", e.is_read ? "read " : "write", cyc, bus0.out_read_data);
      end else if (bus0.out_valid) begin
        chk("spurious_valid", 128'(1), 128'(0));
      end
    end
  end

  task automatic issue(bit row, logic [9:0] addr, logic [127:0] data, bit keep);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.out_ready && n < 50);
    if (!bus0.out_ready) begin
      chk("ready_timeout", 128'(0), 128'(1));
      return;
    end
    bus0.in_req        = 1'b1;
    bus0.in_row        = row;
    bus0.in_addr       = addr;
    bus0.in_write_data = data;
    @(posedge clk);
    acc       = cyc;
    acc_valid = 1'b1;
    e.is_read = !row;
    e.due     = acc + LAT + 1;
    e.data    = row ? 128'(0) : ref_mem[addr[9:4]];
    if (row) ref_mem[addr[9:4]] = data;
    exp_q.push_back(e);
    #1;
    if (keep) begin
      bus0.in_row        = 1'($urandom);
      bus0.in_addr       = 10'($urandom);
      bus0.in_write_data = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      bus0.in_req = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic reset_during_busy();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus0.in_req = 1'b0;
    exp_q.delete();
    acc_valid = 1'b0;
    last_rd   = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] d;
    logic [9:0]   a;
    bit           k;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    bus0.in_req = 1'b0; bus0.in_row = 1'b0; bus0.in_addr = '0; bus0.in_write_data = '0;
    bus1.in_req = 1'b0; bus1.in_row = 1'b0; bus1.in_addr = '0; bus1.in_write_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold read, then write/read of block 0
    issue(1'b0, 10'h000, '0, 1'b0);
    issue(1'b1, 10'h000, 128'hFF, 1'b0);
    issue(1'b0, 10'h000, '0, 1'b0);
    drain();
`ifdef MAIN_MEM_DEBUG_PORT_EN
    dbg_addr = 10'h000;
    #1 chk("dbg_byte0", 128'(dbg_byte), 128'hFF);
    chk("dbg_writes", 128'(dbg_writes), 128'(1));
    dbg_addr = 10'h001;
    #1 chk("dbg_byte1", 128'(dbg_byte), 128'h00);
`endif

    // Distinct blocks, offset bits ignored
    d = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 10'h200, d, 1'b0);
    issue(1'b0, 10'h200, '0, 1'b0);
    issue(1'b0, 10'h000, '0, 1'b0);
    issue(1'b0, 10'h20F, '0, 1'b0);

    // Request held high across three reads, address scrambled while busy
    issue(1'b0, 10'h20F, '0, 1'b1);
    issue(1'b0, 10'h005, '0, 1'b1);
    issue(1'b0, 10'h200, '0, 1'b0);
    drain();

    // Randomized traffic over a few blocks
    for (int i = 0; i < 40; i++) begin
      a = {3'($urandom_range(0, 7)), 3'b000, 4'($urandom)};
      d = {$urandom, $urandom, $urandom, $urandom};
      k = (i != 39) && ($urandom_range(0, 2) == 0);
      issue(1'($urandom), a, d, k);
    end
    drain();

    // Reset while a write is in flight
    issue(1'b1, 10'h300, {4{32'hA5A5_5A5A}}, 1'b0);
    reset_during_busy();
    issue(1'b0, 10'h300, '0, 1'b0);
    drain();

    // LATENCY=1 instance: write then read of the same block with req held
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("l1_ready_idle", 128'(bus1.out_ready), 128'(1));
    bus1.in_req = 1'b1; bus1.in_row = 1'b1; bus1.in_addr = 10'h040; bus1.in_write_data = d;
    @(negedge clk);
    chk("l1_wr_valid", 128'(bus1.out_valid), 128'(1));
    chk("l1_wr_ready", 128'(bus1.out_ready), 128'(0));
    bus1.in_row = 1'b0;
    @(negedge clk);
    chk("l1_idle_valid", 128'(bus1.out_valid), 128'(0));
    chk("l1_idle_ready", 128'(bus1.out_ready), 128'(1));
    @(negedge clk);
    chk("l1_rd_valid", 128'(bus1.out_valid), 128'(1));
    chk("l1_rd_data", bus1.out_read_data, d);
    @(negedge clk);
    chk("l1_gap_valid", 128'(bus1.out_valid), 128'(0));
    @(negedge clk);
    chk("l1_period2_valid", 128'(bus1.out_valid), 128'(1));
    bus1.in_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
